// File: rtl/fp8_mul_arbiter.sv
// Round-robin arbiter that shares one combinational FP8 multiplier between two requesters.
// Operands are held for MUL_LATENCY cycles, then the product is captured and returned to the winner.
module fp8_mul_arbiter #(
  parameter int MUL_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_op1,
  input  logic [7:0]       req0_op2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_op1,
  input  logic [7:0]       req1_op2,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [7:0]       rsp_res,
  output logic [7:0]       mul_op1,
  output logic [7:0]       mul_op2,
  input  logic [7:0]       mul_res,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MUL_LATENCY - 1);

  state_t           r_state;
  logic             r_last_grant;
  logic             r_grant_id;
  logic [3:0]       r_cnt;
  logic [7:0]       r_op1;
  logic [7:0]       r_op2;
  logic [7:0]       r_rsp_res;
  logic [CNT_W-1:0] r_op_count;

  logic w_grant;
  logic w_req_hs;
  logic w_rsp_hs;

  // Contention goes to the requester not served last; a lone requester always wins.
  assign w_grant    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign req0_ready = (r_state == IDLE) && !w_grant && req0_valid;
  assign req1_ready = (r_state == IDLE) &&  w_grant && req1_valid;
  assign w_req_hs   = req0_ready || req1_ready;
  assign w_rsp_hs   = r_grant_id ? rsp1_ready : rsp0_ready;

  assign rsp0_valid = (r_state == RESP) && !r_grant_id;
  assign rsp1_valid = (r_state == RESP) &&  r_grant_id;
  assign rsp_res    = r_rsp_res;
  assign mul_op1    = r_op1;
  assign mul_op2    = r_op2;
  assign busy       = (r_state != IDLE);
  assign op_count   = r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_cnt        <= 4'd0;
      r_op1        <= 8'd0;
      r_op2        <= 8'd0;
      r_rsp_res    <= 8'd0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_hs) begin
            r_op1      <= w_grant ? req1_op1 : req0_op1;
            r_op2      <= w_grant ? req1_op2 : req0_op2;
            r_grant_id <= w_grant;
            r_cnt      <= LAT_M1;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            r_rsp_res <= mul_res;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_last_grant <= r_grant_id;
            r_op_count   <= r_op_count + CNT_W'(1);
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// Bench for fp8_mul_arbiter: two instances (latency 1 and 4) driven by directed and random
// traffic, checked every cycle against a transaction-timeline model of the arbiter.
module tb_fp8_mul_arbiter;

  logic       clk = 1'b0;
  logic       rstN [2];
  logic       v0 [2];
  logic       v1 [2];
  logic       rr0 [2];
  logic       rr1 [2];
  logic [7:0] a0 [2];
  logic [7:0] b0 [2];
  logic [7:0] a1 [2];
  logic [7:0] b1 [2];
  logic       rdy0 [2];
  logic       rdy1 [2];
  logic       rv0 [2];
  logic       rv1 [2];
  logic       busyO [2];
  logic [7:0] rspRes [2];
  logic [7:0] mulOp1 [2];
  logic [7:0] mulOp2 [2];
  logic [7:0] mulRes [2];
  logic [15:0] opCount [2];
  bit         corrupt [2];

  bit         mIdle [2];
  bit         mLast [2];
  bit         mId [2];
  logic [7:0] mOp1 [2];
  logic [7:0] mOp2 [2];
  int         mAge [2];
  logic [15:0] mCount [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Reference FP8 product (s|eee|ffff, bias 3, truncating, flush/saturate at the range ends).
  function automatic logic [7:0] fmul(input logic [7:0] x, input logic [7:0] y);
    int ex, ey, e, p;
    logic s;
    s  = x[7] ^ y[7];
    ex = int'(x[6:4]);
    ey = int'(y[6:4]);
    if (ex == 0 || ey == 0) return {s, 7'd0};
    p = (16 + int'(x[3:0])) * (16 + int'(y[3:0]));
    e = ex + ey - 3;
    if (p >= 512) begin
      p = p / 2;
      e = e + 1;
    end
    if (e <= 0) return {s, 7'd0};
    if (e > 7) return {s, 7'h7F};
    return {s, 3'(e), 4'(p / 16 - 16)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gDut
    assign mulRes[g] = fmul(mulOp1[g], mulOp2[g]) ^ (corrupt[g] ? 8'hFF : 8'h00);

    fp8_mul_arbiter #(.MUL_LATENCY(g == 0 ? 1 : 4), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rstN[g]),
      .req0_valid (v0[g]),
      .req0_ready (rdy0[g]),
      .req0_op1   (a0[g]),
      .req0_op2   (b0[g]),
      .req1_valid (v1[g]),
      .req1_ready (rdy1[g]),
      .req1_op1   (a1[g]),
      .req1_op2   (b1[g]),
      .rsp0_valid (rv0[g]),
      .rsp0_ready (rr0[g]),
      .rsp1_valid (rv1[g]),
      .rsp1_ready (rr1[g]),
      .rsp_res    (rspRes[g]),
      .mul_op1    (mulOp1[g]),
      .mul_op2    (mulOp2[g]),
      .mul_res    (mulRes[g]),
      .busy       (busyO[g]),
      .op_count   (opCount[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Each accepted request is followed by LAT quiet cycles, then a held response until consumed.
  task automatic modelStep(input int k);
    int lat;
    logic e0, e1;
    lat = (k == 0) ? 1 : 4;
    corrupt[k] = 1'b0;
    if (!rstN[k]) begin
      checkOutput("rst_outs", 64'({rdy0[k], rdy1[k], rv0[k], rv1[k], busyO[k], rspRes[k],
                                   mulOp1[k], mulOp2[k], opCount[k]}), 64'd0);
      mIdle[k] = 1'b1; mLast[k] = 1'b1; mCount[k] = 16'd0; mOp1[k] = 8'd0; mOp2[k] = 8'd0;
      return;
    end
    checkOutput("op_count", 64'(opCount[k]), 64'(mCount[k]));
    checkOutput("mul_ops", 64'({mulOp1[k], mulOp2[k]}), 64'({mOp1[k], mOp2[k]}));
    if (mIdle[k]) begin
      e0 = v0[k] && (!v1[k] || mLast[k]);
      e1 = v1[k] && (!v0[k] || !mLast[k]);
      checkOutput("ready", 64'({rdy0[k], rdy1[k]}), 64'({e0, e1}));
      checkOutput("idle_outs", 64'({busyO[k], rv0[k], rv1[k]}), 64'd0);
      if (e0 || e1) begin
        mIdle[k] = 1'b0;
        mId[k]   = e1;
        mOp1[k]  = e1 ? a1[k] : a0[k];
        mOp2[k]  = e1 ? b1[k] : b0[k];
        mAge[k]  = 0;
      end
    end else begin
      mAge[k] = mAge[k] + 1;
      checkOutput("busy_outs", 64'({busyO[k], rdy0[k], rdy1[k]}), 64'(3'b100));
      if (mAge[k] <= lat) begin
        checkOutput("early_rsp", 64'({rv0[k], rv1[k]}), 64'd0);
        if (mAge[k] < lat) corrupt[k] = (k == 1);
      end else begin
        checkOutput("rsp_valid", 64'({rv0[k], rv1[k]}), mId[k] ? 64'd1 : 64'd2);
        checkOutput("rsp_res", 64'(rspRes[k]), 64'(fmul(mOp1[k], mOp2[k])));
        if (mId[k] ? rr1[k] : rr0[k]) begin
          mLast[k]  = mId[k];
          mCount[k] = mCount[k] + 16'd1;
          mIdle[k]  = 1'b1;
        end
      end
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitRsp(input int k, input bit ch, output int n);
    n = 0;
    while (((ch ? rv1[k] : rv0[k]) == 1'b0) && n < 12) begin
      stepCycle();
      n++;
    end
    checkOutput("rsp_timeout", 64'(n < 12), 64'd1);
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      for (int k = 0; k < 2; k++) begin
        v0[k]  = ($urandom_range(0, 2) != 0);
        v1[k]  = ($urandom_range(0, 2) != 0);
        a0[k]  = 8'($urandom);
        b0[k]  = 8'($urandom);
        a1[k]  = 8'($urandom);
        b1[k]  = 8'($urandom);
        rr0[k] = ($urandom_range(0, 3) != 0);
        rr1[k] = ($urandom_range(0, 3) != 0);
      end
      stepCycle();
    end
  endtask

  initial begin
    int n;
    int resps;
    bit expNext;
    for (int k = 0; k < 2; k++) begin
      rstN[k] = 1'b0; v0[k] = 1'b0; v1[k] = 1'b0; rr0[k] = 1'b0; rr1[k] = 1'b0;
      a0[k] = 8'd0; b0[k] = 8'd0; a1[k] = 8'd0; b1[k] = 8'd0;
      corrupt[k] = 1'b0; mIdle[k] = 1'b1; mLast[k] = 1'b1; mId[k] = 1'b0;
      mOp1[k] = 8'd0; mOp2[k] = 8'd0; mAge[k] = 0; mCount[k] = 16'd0;
    end
    repeat (3) stepCycle();
    rstN[0] = 1'b1;
    rstN[1] = 1'b1;
    stepCycle();

    // Single request, latency 1: 1.5 x 1.5.
    v0[0] = 1'b1; a0[0] = 8'h38; b0[0] = 8'h38; rr0[0] = 1'b1;
    #1;
    checkOutput("t1_ready", 64'(rdy0[0]), 64'd1);
    stepCycle();
    v0[0] = 1'b0;
    waitRsp(0, 1'b0, n);
    checkOutput("t1_latency", 64'(n), 64'd1);
    checkOutput("t1_res", 64'(rspRes[0]), 64'h42);
    stepCycle();
    checkOutput("t1_count", 64'(opCount[0]), 64'd1);

    // Both requesters continuously valid: grants alternate, starting with req1.
    v0[0] = 1'b1; a0[0] = 8'h40; b0[0] = 8'h40;
    v1[0] = 1'b1; a1[0] = 8'h40; b1[0] = 8'hC0;
    rr0[0] = 1'b1; rr1[0] = 1'b1;
    expNext = 1'b1;
    resps = 0;
    for (int i = 0; i < 24; i++) begin
      stepCycle();
      if (rv0[0] || rv1[0]) begin
        checkOutput("t2_grant", 64'({rv0[0], rv1[0]}), expNext ? 64'd1 : 64'd2);
        checkOutput("t2_res", 64'(rspRes[0]), expNext ? 64'hD0 : 64'h50);
        expNext = !expNext;
        resps++;
      end
    end
    checkOutput("t2_resps", 64'(resps >= 7), 64'd1);
    v0[0] = 1'b0; v1[0] = 1'b0;
    repeat (4) stepCycle();

    // Response back-pressure on req0 while req1 waits.
    v0[0] = 1'b1; a0[0] = 8'h40; b0[0] = 8'h40; rr0[0] = 1'b0; rr1[0] = 1'b0;
    stepCycle();
    v0[0] = 1'b0; v1[0] = 1'b1; a1[0] = 8'h40; b1[0] = 8'hC0;
    waitRsp(0, 1'b0, n);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t4_hold", 64'({rv0[0], rdy1[0], rspRes[0]}), 64'({1'b1, 1'b0, 8'h50}));
      stepCycle();
    end
    rr0[0] = 1'b1;
    stepCycle();
    checkOutput("t4_next", 64'(rdy1[0]), 64'd1);
    rr0[0] = 1'b0; rr1[0] = 1'b1;
    stepCycle();
    v1[0] = 1'b0;
    waitRsp(0, 1'b1, n);
    checkOutput("t4_res", 64'(rspRes[0]), 64'hD0);
    stepCycle();

    // req1 alone right after its own completion is still granted at once.
    v1[0] = 1'b1; a1[0] = 8'h30; b1[0] = 8'h30;
    #1;
    checkOutput("t3_ready", 64'(rdy1[0]), 64'd1);
    stepCycle();
    v1[0] = 1'b0;
    waitRsp(0, 1'b1, n);
    checkOutput("t3_res", 64'(rspRes[0]), 64'h30);
    stepCycle();

    // Latency 4: operands held, early multiplier glitches must not be captured.
    v0[1] = 1'b1; a0[1] = 8'h40; b0[1] = 8'h40; rr0[1] = 1'b1;
    stepCycle();
    v0[1] = 1'b0;
    n = 0;
    while (!rv0[1] && n < 12) begin
      checkOutput("t5_ops", 64'({mulOp1[1], mulOp2[1]}), 64'h4040);
      stepCycle();
      n++;
    end
    checkOutput("t5_latency", 64'(n), 64'd4);
    checkOutput("t5_res", 64'(rspRes[1]), 64'h50);
    stepCycle();

    applyStimulus(1500);

    // Reset pulsed in the middle of an operation.
    for (int k = 0; k < 2; k++) begin
      v0[k] = 1'b0; v1[k] = 1'b0; rr0[k] = 1'b1; rr1[k] = 1'b1;
    end
    repeat (8) stepCycle();
    v0[1] = 1'b1; a0[1] = 8'h38; b0[1] = 8'h38;
    stepCycle();
    v0[1] = 1'b0;
    stepCycle();
    checkOutput("t6_busy", 64'(busyO[1]), 64'd1);
    rstN[1] = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("t6_no_rsp", 64'({rv0[1], rv1[1], opCount[1]}), 64'd0);
    rstN[1] = 1'b1;
    v0[1] = 1'b1; v1[1] = 1'b1; a1[1] = 8'h30; b1[1] = 8'h30;
    #1;
    checkOutput("t6_grant", 64'({rdy0[1], rdy1[1]}), 64'd2);
    stepCycle();
    v0[1] = 1'b0; v1[1] = 1'b0;
    repeat (8) stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
